// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with saturating direction counters,
// EX-stage control-transfer resolution with one-cycle redirect, a saturating
// misprediction counter and a synthesisable halt drain FSM.
module branch_predict_unit #(
  parameter int PC_W       = 9,
  parameter int ENTRIES    = 16,
  parameter int CNT_W      = 2,
  parameter int HALT_DRAIN = 2
) (
  input  logic            clk,
  input  logic            reset,
  // prediction side (IF)
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [31:0]     pred_target,
  // resolution side (EX)
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [31:0]     ex_imm,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic [31:0]     ex_alu_result,
  input  logic [31:0]     ex_jalr_src,
  input  logic            ex_pred_taken,
  input  logic [31:0]     ex_pred_target,
  output logic [31:0]     pc_four,
  output logic            pc_sel,
  output logic [31:0]     br_pc,
  output logic            mispredict,
  // halt / status
  input  logic            halt,
  output logic            halt_done,
  output logic [15:0]     mispred_cnt
);

  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int TAG_W   = PC_W - IDX_W - 2;
  localparam int DRAIN_W = $clog2(HALT_DRAIN + 1);

  localparam logic [CNT_W-1:0] CTR_MAX  = '1;
  localparam logic [CNT_W-1:0] CTR_WEAK = CNT_W'(1) << (CNT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_DONE
  } halt_state_t;

  // BTB storage
  logic             btb_valid  [ENTRIES];
  logic [TAG_W-1:0] btb_tag    [ENTRIES];
  logic [31:0]      btb_target [ENTRIES];
  logic [CNT_W-1:0] btb_ctr    [ENTRIES];

  // Fetch-side and EX-side index/tag split; PC bits [1:0] never index the table
  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];

  // Byte-offset and upper ALU bits are architecturally irrelevant here
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], ex_pc[1:0], ex_alu_result[31:1]};

  // Lookup: reads the current (pre-update) table, so no same-cycle bypass
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    if_hit      = 1'b0;
    pred_taken  = 1'b0;
    pred_target = '0;
    if_hit      = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
    pred_taken  = if_hit && btb_ctr[if_idx][CNT_W-1];
    if (pred_taken) pred_target = btb_target[if_idx];
  end

  // Resolution of the instruction in EX
  logic [31:0] ex_pc32, ex_tgt;
  logic        ex_ctl, ex_taken, ex_wrong;

  always_comb begin
    ex_pc32  = 32'(ex_pc);
    pc_four  = ex_pc32 + 32'd4;
    ex_ctl   = ex_branch | ex_jal | ex_jalr;
    ex_taken = (ex_branch && ex_alu_result[0]) || ex_jal || ex_jalr;
    ex_tgt   = ex_jalr ? ex_jalr_src : ex_pc32 + ex_imm;
    ex_wrong = (ex_taken != ex_pred_taken) ||
               (ex_taken && (ex_pred_target != ex_tgt));
    ex_hit   = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
    pc_sel   = ex_valid && ex_wrong;
    br_pc    = '0;
    if (ex_valid) br_pc = ex_taken ? ex_tgt : pc_four;
  end

  assign mispredict = pc_sel;

  // BTB training from the resolved EX instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the table is cleared on reset because a stale valid bit would make fetch follow a garbage target; that is why it is flops, not a RAM.
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= '0;
      end
    end else if (ex_valid) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (ex_ctl) begin
        if (ex_hit) begin
          if (ex_taken) begin
            btb_target[ex_idx] <= ex_tgt;
            if (btb_ctr[ex_idx] != CTR_MAX)
              btb_ctr[ex_idx] <= btb_ctr[ex_idx] + CNT_W'(1);
          end else if (btb_ctr[ex_idx] != '0) begin
            btb_ctr[ex_idx] <= btb_ctr[ex_idx] - CNT_W'(1);
          end
        end else if (ex_taken) begin
          btb_valid[ex_idx]  <= 1'b1;
          btb_tag[ex_idx]    <= ex_tag;
          btb_target[ex_idx] <= ex_tgt;
          btb_ctr[ex_idx]    <= CTR_WEAK;
        end
      end else if (ex_hit) begin
        // a non-control instruction aliases onto this entry: drop it
        btb_valid[ex_idx] <= 1'b0;
      end
    end
  end

  // Saturating misprediction counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispred_cnt <= '0;
    end else if (mispredict && (mispred_cnt != 16'hFFFF)) begin
      mispred_cnt <= mispred_cnt + 16'd1;
    end
  end

  // Halt drain FSM: halt_done rises HALT_DRAIN edges after halt is accepted
  halt_state_t        halt_state;
  logic [DRAIN_W-1:0] drain_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt_state <= ST_IDLE;
      drain_cnt  <= '0;
      halt_done  <= 1'b0;
    end else begin
      case (halt_state)
        ST_IDLE: begin
          if (halt && ex_valid) begin
            halt_state <= ST_DRAIN;
            drain_cnt  <= DRAIN_W'(HALT_DRAIN - 1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            halt_state <= ST_DONE;
            halt_done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        ST_DONE: begin
          halt_done <= 1'b1;
        end
        default: begin
          halt_state <= ST_IDLE;
          halt_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: the driver computes the expected
// response of each cycle from a behavioural BTB model and queues it; a
// monitor on the falling edge pops and compares against the DUT outputs.
module tb_branch_predict_unit;

  localparam int PC_W       = 9;
  localparam int ENTRIES    = 16;
  localparam int CNT_W      = 2;
  localparam int HALT_DRAIN = 2;
  localparam int CTR_TOP    = (1 << CNT_W) - 1;
  localparam int CTR_HALF   = 1 << (CNT_W - 1);

  logic            clk, reset;
  logic [PC_W-1:0] if_pc, ex_pc;
  logic            pred_taken;
  logic [31:0]     pred_target;
  logic            ex_valid, ex_branch, ex_jal, ex_jalr;
  logic [31:0]     ex_imm, ex_alu_result, ex_jalr_src, ex_pred_target;
  logic            ex_pred_taken;
  logic [31:0]     pc_four, br_pc;
  logic            pc_sel, mispredict, halt, halt_done;
  logic [15:0]     mispred_cnt;

  branch_predict_unit #(
    .PC_W(PC_W), .ENTRIES(ENTRIES), .CNT_W(CNT_W), .HALT_DRAIN(HALT_DRAIN)
  ) dut (
    .clk(clk), .reset(reset),
    .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_alu_result(ex_alu_result), .ex_jalr_src(ex_jalr_src),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc_four(pc_four), .pc_sel(pc_sel), .br_pc(br_pc), .mispredict(mispredict),
    .halt(halt), .halt_done(halt_done), .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        pt;
    logic [31:0] ptg;
    logic [31:0] pc4;
    logic        sel;
    logic [31:0] brpc;
    logic        hd;
    logic [15:0] mcnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_mcnt;
  int          m_halt_at;
  int          cyc;

  function automatic int unsigned idx_of(input int unsigned pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input int unsigned pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit model_hit(input int unsigned pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  task automatic model_lookup(input int unsigned pc, output bit pt, output logic [31:0] ptg);
    pt  = model_hit(pc) && (m_ctr[idx_of(pc)] >= CTR_HALF);
    ptg = pt ? m_tgt[idx_of(pc)] : 32'h0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = 32'h0;
      m_ctr[i]   = 0;
    end
    m_mcnt    = 0;
    m_halt_at = -1;
  endtask

  // One cycle of stimulus. cls: 0 = non-control, 1 = branch, 2 = jal, 3 = jalr.
  task automatic drive(input logic [PC_W-1:0] ipc, input bit v, input logic [PC_W-1:0] epc,
                       input logic [31:0] imm, input int cls, input bit alu0,
                       input logic [31:0] jsrc, input bit ept, input logic [31:0] eptg,
                       input bit hlt, input bit rst_cycle);
    exp_t        e;
    logic [31:0] alu, tgt, pc4;
    bit          taken, mis, pt;
    logic [31:0] ptg;
    int unsigned j;
    @(posedge clk);
    #1;
    if (rst_cycle) begin
      v   = 1'b0;
      hlt = 1'b0;
      reset = 1'b1;
      model_clear();
    end
    alu = $urandom();
    alu[0] = alu0;
    if_pc          = ipc;
    ex_valid       = v;
    ex_pc          = epc;
    ex_imm         = imm;
    ex_branch      = (cls == 1);
    ex_jal         = (cls == 2);
    ex_jalr        = (cls == 3);
    ex_alu_result  = alu;
    ex_jalr_src    = jsrc;
    ex_pred_taken  = ept;
    ex_pred_target = eptg;
    halt           = hlt;

    // expected response for this cycle, from pre-update model state
    model_lookup(ipc, pt, ptg);
    pc4   = 32'(epc) + 32'd4;
    taken = (cls == 1) ? alu0 : (cls >= 2);
    tgt   = (cls == 3) ? jsrc : 32'(epc) + imm;
    mis   = v && ((taken != ept) || (taken && (eptg != tgt)));
    e.cyc  = cyc;
    e.pt   = pt;
    e.ptg  = ptg;
    e.pc4  = pc4;
    e.sel  = mis;
    e.brpc = !v ? 32'h0 : (taken ? tgt : pc4);
    e.hd   = (m_halt_at >= 0) && (cyc >= m_halt_at + 1 + HALT_DRAIN);
    e.mcnt = 16'(m_mcnt);
    sb_q.push_back(e);

    // state the next cycle will see
    if (v) begin
      j = idx_of(epc);
      if (cls != 0) begin
        if (model_hit(epc)) begin
          if (taken) begin
            m_tgt[j] = tgt;
            m_ctr[j] = (m_ctr[j] < CTR_TOP) ? m_ctr[j] + 1 : CTR_TOP;
          end else begin
            m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
          end
        end else if (taken) begin
          m_valid[j] = 1'b1;
          m_tag[j]   = tag_of(epc);
          m_tgt[j]   = tgt;
          m_ctr[j]   = CTR_HALF;
        end
      end else if (model_hit(epc)) begin
        m_valid[j] = 1'b0;
      end
      if (hlt && (m_halt_at < 0)) m_halt_at = cyc;
    end
    if (mis && (m_mcnt < 65535)) m_mcnt++;
    cyc++;
    if (rst_cycle) begin
      @(negedge clk);
      #1;
      reset = 1'b0;
    end
  endtask

  task automatic idle(input logic [PC_W-1:0] ipc);
    drive(ipc, 1'b0, '0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic [PC_W-1:0] ipc);
    drive(ipc, 1'b0, '0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("pred_taken",  e.cyc, 32'(pred_taken),  32'(e.pt));
        check("pred_target", e.cyc, pred_target,      e.ptg);
        check("pc_four",     e.cyc, pc_four,          e.pc4);
        check("pc_sel",      e.cyc, 32'(pc_sel),      32'(e.sel));
        check("mispredict",  e.cyc, 32'(mispredict),  32'(e.sel));
        check("br_pc",       e.cyc, br_pc,            e.brpc);
        check("halt_done",   e.cyc, 32'(halt_done),   32'(e.hd));
        check("mispred_cnt", e.cyc, 32'(mispred_cnt), 32'(e.mcnt));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [PC_W-1:0] pool [8];

  initial begin
    reset = 1'b1;
    if_pc = '0; ex_pc = '0; ex_valid = 1'b0; ex_imm = '0;
    ex_branch = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0;
    ex_alu_result = '0; ex_jalr_src = '0;
    ex_pred_taken = 1'b0; ex_pred_target = '0; halt = 1'b0;
    cyc = 0;
    model_clear();

    // reset state with if_pc = 0x40
    do_reset(9'h040);
    idle(9'h040);

    // cold taken beq at 0x40, imm 0x10: redirect to 0x50, then learned
    drive(9'h040, 1, 9'h040, 32'h10, 1, 1, 32'h0, 0, 32'h0, 0, 0);
    idle(9'h040);

    // hysteresis: taken x3, not-taken, lookup, not-taken, lookup
    repeat (3) drive(9'h040, 1, 9'h040, 32'h10, 1, 1, 32'h0, 1, 32'h50, 0, 0);
    drive(9'h040, 1, 9'h040, 32'h10, 1, 0, 32'h0, 1, 32'h50, 0, 0);
    idle(9'h040);
    drive(9'h040, 1, 9'h040, 32'h10, 1, 0, 32'h0, 1, 32'h50, 0, 0);
    idle(9'h040);

    // jalr at 0x84: learn 0x80, then target changes to 0x90
    drive(9'h084, 1, 9'h084, 32'h0, 3, 0, 32'h80, 0, 32'h0, 0, 0);
    idle(9'h084);
    drive(9'h084, 1, 9'h084, 32'h0, 3, 0, 32'h90, 1, 32'h80, 0, 0);
    idle(9'h084);

    // alias: non-control at 0x84 with simultaneous lookup of 0x84
    drive(9'h084, 1, 9'h084, 32'h0, 0, 0, 32'h0, 1, 32'h90, 0, 0);
    idle(9'h084);

    // wrap-around target arithmetic
    drive(9'h1FC, 1, 9'h1FC, 32'hFFFF_FE00, 2, 0, 32'h0, 0, 32'h0, 0, 0);
    idle(9'h1FC);

    // halt drain, then halt again with reset one cycle into the drain
    drive(9'h040, 1, 9'h010, 32'h0, 0, 0, 32'h0, 0, 32'h0, 1, 0);
    repeat (4) idle(9'h040);
    drive(9'h040, 1, 9'h010, 32'h0, 0, 0, 32'h0, 0, 32'h0, 1, 0);
    idle(9'h040);
    do_reset(9'h040);
    drive(9'h040, 1, 9'h010, 32'h0, 0, 0, 32'h0, 0, 32'h0, 1, 0);
    do_reset(9'h040);
    repeat (4) idle(9'h040);

    // randomized traffic over a small PC pool so entries hit and alias
    pool[0] = 9'h040; pool[1] = 9'h044; pool[2] = 9'h080; pool[3] = 9'h1C0;
    pool[4] = 9'h084; pool[5] = 9'h010; pool[6] = 9'h013; pool[7] = 9'h1FC;
    for (int n = 0; n < 2000; n++) begin
      logic [PC_W-1:0] ipc, epc;
      logic [31:0]     imm, jsrc, eptg;
      bit              v, ept, hlt, rs;
      int              cls, sel;
      ipc = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 7)] : PC_W'($urandom());
      epc = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 7)] : PC_W'($urandom());
      v   = ($urandom_range(0, 99) < 85);
      cls = $urandom_range(0, 3);
      sel = $urandom_range(0, 3);
      imm  = (sel == 0) ? 32'h10 : (sel == 1) ? 32'hFFFF_FFF8 :
             (sel == 2) ? 32'hFFFF_FF00 + $urandom_range(0, 255) : $urandom();
      sel  = $urandom_range(0, 2);
      jsrc = (sel == 0) ? 32'h80 : (sel == 1) ? 32'h90 : $urandom();
      if ($urandom_range(0, 9) < 7) begin
        model_lookup(epc, ept, eptg);
      end else begin
        ept  = $urandom_range(0, 1);
        eptg = ($urandom_range(0, 1) == 1) ? 32'(epc) + imm : $urandom();
      end
      hlt = ($urandom_range(0, 299) == 0);
      rs  = ($urandom_range(0, 249) == 0);
      drive(ipc, v, epc, imm, cls, 1'($urandom_range(0, 1)), jsrc, ept, eptg, hlt, rs);
    end

    // let the monitor drain the scoreboard, bounded
    for (int w = 0; w < 4 && sb_q.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0 pending", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
